// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared types and constants for the 1:4 TDM demultiplexer.
//   state_t : receiver framing state (HUNT waits for a sync, COLLECT fills a frame)
//   NCH     : number of interleaved channels in one TDM frame
//   SLOT_W  : width of the slot index that selects a channel
// ---------------------------------------------------------------------------
package demux_pkg;

    typedef enum logic {
        HUNT,
        COLLECT
    } state_t;

    localparam int NCH    = 4;
    localparam int SLOT_W = 2;

endpackage

// File: rtl/demux_1_4_tdm_if.sv
// ---------------------------------------------------------------------------
// demux_1_4_tdm_if
// Bundles the serial input side and the parallel output side of the TDM
// demultiplexer.
//   din, din_valid, frame_sync : serial beat stream (driven by the source)
//   y0..y3                     : last completed channel words
//   out_valid, frame_err       : one-cycle strobes
//   s1, s0                     : slot of the next expected beat
// Modports:
//   master : the stream source / observer of the demux outputs
//   slave  : the demultiplexer itself
// ---------------------------------------------------------------------------
interface demux_1_4_tdm_if #(
    parameter int WIDTH = 8
);

    logic             din;
    logic             din_valid;
    logic             frame_sync;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH-1:0] y3;
    logic             out_valid;
    logic             frame_err;
    logic             s1;
    logic             s0;

    modport master (
        output din, din_valid, frame_sync,
        input  y0, y1, y2, y3, out_valid, frame_err, s1, s0
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output y0, y1, y2, y3, out_valid, frame_err, s1, s0
    );

endinterface

// File: rtl/demux_1_4_tdm_slot_counter.sv
// ---------------------------------------------------------------------------
// tdm_slot_counter
// Tracks where the next beat lands inside a TDM frame.
//   clk, rst  : clock and asynchronous active-high reset
//   inc       : advance by one beat
//   clear     : return to slot 0 / bit 0; together with inc the current beat
//               counts as slot 0 / bit 0, so the counter lands on slot 1 / bit 0
//   slot      : channel of the next expected beat (mod 4)
//   bit_cnt   : bit position inside each channel word
//   last_beat : the next beat completes the frame (slot 3, last bit)
// ---------------------------------------------------------------------------
module tdm_slot_counter
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BIT_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              clear,
    output logic [SLOT_W-1:0] slot,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic              last_beat
);

    logic slot_wrap;
    logic bit_wrap;

    // The bit position only advances once all four channels have received
    // a beat; wrapping is explicit so non-power-of-two widths still work.
    assign slot_wrap = (slot == SLOT_W'(NCH - 1));
    assign bit_wrap  = (bit_cnt == BIT_W'(WIDTH - 1));
    assign last_beat = slot_wrap && bit_wrap;

    // Counter register. A clear with inc means "this beat starts a frame",
    // so the beat itself consumes slot 0 and the counter moves to slot 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot    <= '0;
            bit_cnt <= '0;
        end else if (clear && inc) begin
            slot    <= SLOT_W'(1);
            bit_cnt <= '0;
        end else if (clear) begin
            slot    <= '0;
            bit_cnt <= '0;
        end else if (inc) begin
            slot <= slot + 1'b1;
            if (slot_wrap) begin
                bit_cnt <= bit_wrap ? '0 : bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_1_4_tdm.sv
// ---------------------------------------------------------------------------
// demux_1_4_tdm
// Receive end of a 4:1 TDM link. Rebuilds four WIDTH-bit channel words from
// a serial stream interleaved ch0,ch1,ch2,ch3,ch0,... (MSB first), aligned
// by a frame_sync marker on the first beat of every frame.
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-high reset
//   bus : demux_1_4_tdm_if slave modport
//         din/din_valid/frame_sync in, y0..y3/out_valid/frame_err/s1/s0 out
// A completed frame appears on y0..y3 one clock after its last beat with a
// single-cycle out_valid. Alignment problems give a single-cycle frame_err.
// ---------------------------------------------------------------------------
module demux_1_4_tdm
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    demux_1_4_tdm_if.slave bus
);

    localparam int BIT_W = $clog2(WIDTH);

    state_t            state;
    state_t            state_next;
    logic [SLOT_W-1:0] slot;
    logic [BIT_W-1:0]  bit_cnt;
    logic              last_beat;
    logic              at_start;

    logic              cnt_inc;
    logic              cnt_clear;
    logic              do_start;
    logic              do_shift;
    logic              do_done;
    logic              do_err;

    logic [WIDTH-1:0]  sr [NCH];
    logic [WIDTH-1:0]  sr_shifted;
    logic [WIDTH-1:0]  y_q [NCH];
    logic              out_valid_q;
    logic              frame_err_q;

    tdm_slot_counter #(
        .WIDTH (WIDTH),
        .BIT_W (BIT_W)
    ) u_slot_counter (
        .clk       (clk),
        .rst       (rst),
        .inc       (cnt_inc),
        .clear     (cnt_clear),
        .slot      (slot),
        .bit_cnt   (bit_cnt),
        .last_beat (last_beat)
    );

    // A frame may only begin where the counter expects slot 0 / bit 0.
    assign at_start   = (slot == '0) && (bit_cnt == '0);
    assign sr_shifted = {sr[slot][WIDTH-2:0], bus.din};

    // Framing state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Only valid beats move the FSM; a beat that should
    // have carried a sync but did not sends us back to hunting.
    always_comb begin
        state_next = state;
        if (bus.din_valid) begin
            case (state)
                HUNT: begin
                    if (bus.frame_sync) begin
                        state_next = COLLECT;
                    end
                end
                COLLECT: begin
                    if (!bus.frame_sync && at_start) begin
                        state_next = HUNT;
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    // Control decode for the current beat. A sync that arrives anywhere but
    // slot 0 / bit 0 restarts the frame on this beat and flags an error; a
    // sync on the final beat of a frame is such an early sync, so the frame
    // is dropped rather than completed.
    always_comb begin
        cnt_inc   = 1'b0;
        cnt_clear = 1'b0;
        do_start  = 1'b0;
        do_shift  = 1'b0;
        do_done   = 1'b0;
        do_err    = 1'b0;
        if (bus.din_valid) begin
            case (state)
                HUNT: begin
                    if (bus.frame_sync) begin
                        do_start  = 1'b1;
                        cnt_clear = 1'b1;
                        cnt_inc   = 1'b1;
                    end
                end
                COLLECT: begin
                    if (bus.frame_sync && !at_start) begin
                        do_err    = 1'b1;
                        do_start  = 1'b1;
                        cnt_clear = 1'b1;
                        cnt_inc   = 1'b1;
                    end else if (!bus.frame_sync && at_start) begin
                        do_err    = 1'b1;
                        cnt_clear = 1'b1;
                    end else begin
                        do_shift  = 1'b1;
                        cnt_inc   = 1'b1;
                        do_done   = last_beat;
                    end
                end
                default: begin
                    cnt_clear = 1'b1;
                end
            endcase
        end
    end

    // Per-channel shift registers. Starting a frame clears leftovers from a
    // discarded partial frame and drops the first bit into channel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < NCH; ch++) begin
                sr[ch] <= '0;
            end
        end else if (do_start) begin
            for (int ch = 0; ch < NCH; ch++) begin
                sr[ch] <= (ch == 0) ? {{(WIDTH-1){1'b0}}, bus.din} : '0;
            end
        end else if (do_shift) begin
            sr[slot] <= sr_shifted;
        end
    end

    // Output words and strobes. The final beat belongs to channel 3, so its
    // word is taken from the shifted value rather than the stale register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < NCH; ch++) begin
                y_q[ch] <= '0;
            end
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            out_valid_q <= do_done;
            frame_err_q <= do_err;
            if (do_done) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    y_q[ch] <= (SLOT_W'(ch) == slot) ? sr_shifted : sr[ch];
                end
            end
        end
    end

    assign bus.y0        = y_q[0];
    assign bus.y1        = y_q[1];
    assign bus.y2        = y_q[2];
    assign bus.y3        = y_q[3];
    assign bus.out_valid = out_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.s1        = slot[1];
    assign bus.s0        = slot[0];

endmodule

// File: tb/tb_demux_1_4_tdm.sv
// ---------------------------------------------------------------------------
// tb_demux_1_4_tdm
// Directed testbench for demux_1_4_tdm with WIDTH=8. Frames are built from
// hand-chosen channel words; expected outputs are those same words.
// ---------------------------------------------------------------------------
module tb_demux_1_4_tdm;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;

    int checksTotal;
    int checksPassed;
    int ovCount;
    int errCount;
    int bothCount;
    int stableViolations;
    bit watchStable;
    logic lastOv;
    logic lastErr;
    logic [31:0] yPrev;
    logic [31:0] yPacked;

    demux_1_4_tdm_if #(.WIDTH(WIDTH)) bus ();

    demux_1_4_tdm #(
        .WIDTH (WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign yPacked = {bus.y0, bus.y1, bus.y2, bus.y3};

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Strobe monitor: counts pulses, catches simultaneous strobes and, when
    // enabled, any change of y0..y3 that is not accompanied by out_valid.
    always @(posedge clk) begin
        #1;
        if (bus.out_valid) ovCount++;
        if (bus.frame_err) errCount++;
        if (bus.out_valid && bus.frame_err) bothCount++;
        if (watchStable && !bus.out_valid && (yPacked != yPrev)) stableViolations++;
        yPrev = yPacked;
    end

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // One valid beat; outputs are sampled 1 unit after the edge that took it.
    task automatic sendBeat(input logic d, input logic s);
        bus.din        = d;
        bus.frame_sync = s;
        bus.din_valid  = 1'b1;
        @(posedge clk);
        #1;
        lastOv         = bus.out_valid;
        lastErr        = bus.frame_err;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
    endtask

    // Idle cycles with frame_sync held high, which the demux must ignore.
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.din_valid  = 1'b0;
            bus.frame_sync = 1'b1;
            bus.din        = 1'($urandom);
            @(posedge clk);
            #1;
        end
        bus.frame_sync = 1'b0;
    endtask

    // Sends the first numBeats beats of a frame built from four words,
    // interleaved by channel, MSB first, sync on beat 0.
    task automatic applyStimulus(input logic [7:0] w0, input logic [7:0] w1,
                                 input logic [7:0] w2, input logic [7:0] w3,
                                 input int numBeats, input bit gaps);
        logic [7:0] words [4];
        words[0] = w0;
        words[1] = w1;
        words[2] = w2;
        words[3] = w3;
        for (int beat = 0; beat < numBeats; beat++) begin
            if (gaps) idleCycles(int'($urandom_range(0, 2)));
            sendBeat(words[beat % 4][7 - (beat / 4)], beat == 0);
        end
    endtask

    task automatic checkWords(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2, input logic [7:0] w3);
        checkOutput({tag, "_y0"}, 32'(bus.y0), 32'(w0));
        checkOutput({tag, "_y1"}, 32'(bus.y1), 32'(w1));
        checkOutput({tag, "_y2"}, 32'(bus.y2), 32'(w2));
        checkOutput({tag, "_y3"}, 32'(bus.y3), 32'(w3));
    endtask

    initial begin
        int ov0;
        int err0;
        logic [7:0] src [4];
        int bitIdx [4];
        logic [1:0] sel;

        checksTotal      = 0;
        checksPassed     = 0;
        ovCount          = 0;
        errCount         = 0;
        bothCount        = 0;
        stableViolations = 0;
        watchStable      = 1'b0;
        bus.din          = 1'b0;
        bus.din_valid    = 1'b0;
        bus.frame_sync   = 1'b0;
        rst              = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("init_y", yPacked, 32'h0);
        checkOutput("init_ov", 32'(bus.out_valid), 32'h0);
        checkOutput("init_err", 32'(bus.frame_err), 32'h0);
        checkOutput("init_slot", 32'({bus.s1, bus.s0}), 32'h0);

        // Single frame, no gaps.
        $display("[TB] single frame");
        ov0 = ovCount; err0 = errCount;
        applyStimulus(8'hA5, 8'h3C, 8'hFF, 8'h00, 32, 1'b0);
        checkOutput("t2_ov_latency", 32'(lastOv), 32'h1);
        checkOutput("t2_ov_count", 32'(ovCount - ov0), 32'h1);
        checkOutput("t2_err_count", 32'(errCount - err0), 32'h0);
        checkWords("t2", 8'hA5, 8'h3C, 8'hFF, 8'h00);

        // Reset in the middle of a frame clears everything within the cycle.
        $display("[TB] reset mid-stream");
        applyStimulus(8'h11, 8'h22, 8'h33, 8'h44, 5, 1'b0);
        checkOutput("t1_slot_before", 32'({bus.s1, bus.s0}), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("t1_y", yPacked, 32'h0);
        checkOutput("t1_ov", 32'(bus.out_valid), 32'h0);
        checkOutput("t1_err", 32'(bus.frame_err), 32'h0);
        checkOutput("t1_slot", 32'({bus.s1, bus.s0}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back frames with random gaps; y must hold between pulses.
        $display("[TB] back-to-back frames with gaps");
        ov0 = ovCount; err0 = errCount;
        watchStable = 1'b1;
        applyStimulus(8'h81, 8'h7E, 8'h55, 8'hAA, 32, 1'b1);
        checkOutput("t3a_ov_latency", 32'(lastOv), 32'h1);
        checkWords("t3a", 8'h81, 8'h7E, 8'h55, 8'hAA);
        applyStimulus(8'h01, 8'h02, 8'h03, 8'h04, 32, 1'b1);
        checkOutput("t3b_ov_latency", 32'(lastOv), 32'h1);
        checkWords("t3b", 8'h01, 8'h02, 8'h03, 8'h04);
        idleCycles(3);
        watchStable = 1'b0;
        checkOutput("t3_ov_count", 32'(ovCount - ov0), 32'h2);
        checkOutput("t3_err_count", 32'(errCount - err0), 32'h0);
        checkOutput("t3_y_stable", 32'(stableViolations), 32'h0);

        // Early sync on beat 10 restarts the frame on that beat.
        $display("[TB] early sync");
        ov0 = ovCount; err0 = errCount;
        applyStimulus(8'hF0, 8'h0F, 8'hC3, 8'h3C, 10, 1'b0);
        applyStimulus(8'h12, 8'h34, 8'h56, 8'h78, 32, 1'b0);
        checkOutput("t4_err_count", 32'(errCount - err0), 32'h1);
        checkOutput("t4_ov_count", 32'(ovCount - ov0), 32'h1);
        checkWords("t4", 8'h12, 8'h34, 8'h56, 8'h78);

        // Missing sync after a full frame drops to HUNT and ignores junk.
        $display("[TB] missing sync");
        ov0 = ovCount; err0 = errCount;
        applyStimulus(8'h9A, 8'hBC, 8'hDE, 8'hF1, 32, 1'b0);
        sendBeat(1'b1, 1'b0);
        checkOutput("t5_err_pulse", 32'(lastErr), 32'h1);
        checkOutput("t5_hunt_slot", 32'({bus.s1, bus.s0}), 32'h0);
        for (int i = 0; i < 20; i++) begin
            sendBeat(1'($urandom), 1'b0);
        end
        checkOutput("t5_junk_slot", 32'({bus.s1, bus.s0}), 32'h0);
        checkOutput("t5_err_count", 32'(errCount - err0), 32'h1);
        checkOutput("t5_ov_count", 32'(ovCount - ov0), 32'h1);
        checkWords("t5_hold", 8'h9A, 8'hBC, 8'hDE, 8'hF1);
        applyStimulus(8'hC0, 8'hFF, 8'hEE, 8'h01, 32, 1'b0);
        checkOutput("t5_ov_latency", 32'(lastOv), 32'h1);
        checkWords("t5", 8'hC0, 8'hFF, 8'hEE, 8'h01);

        // Loopback: a 4:1 mux picks the source channel using the demux slot.
        $display("[TB] loopback");
        ov0 = ovCount; err0 = errCount;
        src[0] = 8'hDE; src[1] = 8'hAD; src[2] = 8'hBE; src[3] = 8'hEF;
        for (int ch = 0; ch < 4; ch++) bitIdx[ch] = 0;
        for (int i = 0; i < 32; i++) begin
            idleCycles(i % 3);
            sel = {bus.s1, bus.s0};
            sendBeat(src[sel][7 - bitIdx[sel]], i == 0);
            bitIdx[sel]++;
        end
        checkOutput("t6_ov_latency", 32'(lastOv), 32'h1);
        checkOutput("t6_ov_count", 32'(ovCount - ov0), 32'h1);
        checkOutput("t6_err_count", 32'(errCount - err0), 32'h0);
        checkWords("t6", 8'hDE, 8'hAD, 8'hBE, 8'hEF);

        checkOutput("no_dual_strobe", 32'(bothCount), 32'h0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
